// File: rtl/fr_pkg.sv
// Shared definitions for the workout controller status path: event codes and
// the buzzer sequencer state encoding.
package fr_pkg;

    localparam logic [1:0] BU_NONE = 2'b00;
    localparam logic [1:0] BU_REST = 2'b01;
    localparam logic [1:0] BU_SKIP = 2'b10;
    localparam logic [1:0] BU_DONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } buzz_state_t;

    // Beeps still to play after the one that starts with the pattern.
    function automatic logic [1:0] extra_beeps(input logic [1:0] code);
        case (code)
            BU_SKIP: extra_beeps = 2'd1;
            BU_DONE: extra_beeps = 2'd2;
            default: extra_beeps = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_cnt9.sv
// 9-bit event counter that sticks at 511 instead of wrapping.
module sat_cnt9 (
    input  logic       Clk,
    input  logic       Re,
    input  logic       Inc,
    output logic [8:0] Count
);

    always_ff @(posedge Clk or posedge Re) begin
        if (Re) begin
            Count <= 9'd0;
        end else if (Inc && (Count != 9'd511)) begin
            Count <= Count + 9'd1;
        end
    end

endmodule

// File: rtl/buzz_driver.sv
// Turns one-cycle status events into beep patterns on the buzzer line, with a
// single-entry pending slot, and keeps the session statistics.
module buzz_driver
    import fr_pkg::*;
#(
    parameter int BEEP_ON  = 8,
    parameter int BEEP_OFF = 4
) (
    input  logic       Clk,
    input  logic       Re,
    input  logic [1:0] Bu,
    input  logic [8:0] Cn,
    output logic       Buz,
    output logic       Busy,
    output logic [8:0] Rests,
    output logic [8:0] Skips,
    output logic [8:0] Total,
    output logic       Done
);

    localparam int TW = $clog2(2 * BEEP_ON + 1);
    localparam logic [TW-1:0] SHORT_LD = TW'(BEEP_ON - 1);
    localparam logic [TW-1:0] LONG_LD  = TW'(2 * BEEP_ON - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(BEEP_OFF - 1);

    buzz_state_t   state;
    logic [1:0]    beeps_left;
    logic          long_beep;
    logic [TW-1:0] timer;
    logic [1:0]    pending;

    logic [1:0]    start_code;
    logic [1:0]    pending_next;
    logic          short_evt;
    logic          last_edge;

    assign short_evt = (Bu == BU_REST) || (Bu == BU_SKIP);
    assign last_edge = (state == OFF) && (timer == '0) && (beeps_left == 2'd0);
    assign Busy      = (state != IDLE);

    // Decide which pattern (if any) starts at this edge and what stays queued.
    always_comb begin
        start_code   = BU_NONE;
        pending_next = pending;
        if (Bu == BU_DONE) begin
            start_code   = BU_DONE;
            pending_next = BU_NONE;
        end else if (state == IDLE) begin
            start_code = Bu;
        end else if (last_edge) begin
            if (pending != BU_NONE) begin
                start_code   = pending;
                pending_next = Bu;
            end else begin
                start_code = Bu;
            end
        end else if (short_evt && (Bu > pending)) begin
            pending_next = Bu;
        end
    end

    always_ff @(posedge Clk or posedge Re) begin
        if (Re) begin
            state      <= IDLE;
            Buz        <= 1'b0;
            beeps_left <= 2'd0;
            long_beep  <= 1'b0;
            timer      <= '0;
            pending    <= BU_NONE;
        end else begin
            pending <= pending_next;
            if (start_code != BU_NONE) begin
                state      <= ON;
                Buz        <= 1'b1;
                long_beep  <= (start_code == BU_DONE);
                timer      <= (start_code == BU_DONE) ? LONG_LD : SHORT_LD;
                beeps_left <= extra_beeps(start_code);
            end else begin
                case (state)
                    ON: begin
                        if (timer == '0) begin
                            state <= OFF;
                            Buz   <= 1'b0;
                            timer <= GAP_LD;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    OFF: begin
                        if (timer != '0) begin
                            timer <= timer - TW'(1);
                        end else if (beeps_left != 2'd0) begin
                            state      <= ON;
                            Buz        <= 1'b1;
                            timer      <= long_beep ? LONG_LD : SHORT_LD;
                            beeps_left <= beeps_left - 2'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        Buz   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Statistics follow the raw event stream, even for patterns that get dropped.
    always_ff @(posedge Clk or posedge Re) begin
        if (Re) begin
            Total <= 9'd0;
            Done  <= 1'b0;
        end else if (Bu == BU_DONE) begin
            Total <= Cn;
            Done  <= 1'b1;
        end
    end

    logic [1:0] cnt_inc;
    logic [8:0] cnt_val [2];

    assign cnt_inc[0] = (Bu == BU_REST);
    assign cnt_inc[1] = (Bu == BU_SKIP);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_cnt9 u_cnt (
                .Clk   (Clk),
                .Re    (Re),
                .Inc   (cnt_inc[gi]),
                .Count (cnt_val[gi])
            );
        end
    endgenerate

    assign Rests = cnt_val[0];
    assign Skips = cnt_val[1];

endmodule

// File: tb/tb_buzz_driver.sv
// Bench for buzz_driver: directed scenarios plus random event streams, checked
// against a schedule-of-buzzer-values model built from the pattern rules.
module tb_buzz_driver;

    localparam int ON_T  = 4;
    localparam int OFF_T = 2;

    logic       Clk;
    logic       Re;
    logic [1:0] Bu;
    logic [8:0] Cn;
    logic       Buz;
    logic       Busy;
    logic [8:0] Rests;
    logic [8:0] Skips;
    logic [8:0] Total;
    logic       Done;

    buzz_driver #(.BEEP_ON(ON_T), .BEEP_OFF(OFF_T)) dut (
        .Clk   (Clk),
        .Re    (Re),
        .Bu    (Bu),
        .Cn    (Cn),
        .Buz   (Buz),
        .Busy  (Busy),
        .Rests (Rests),
        .Skips (Skips),
        .Total (Total),
        .Done  (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests  = 0;
    int failed = 0;
    int nstep  = 0;
    bit drop_reset = 0;

    // Reference model: future buzzer values of the playing pattern, one per cycle.
    int sched[$];
    int pend;
    int m_rests, m_skips, m_total, m_done;

    task automatic model_reset();
        sched.delete();
        pend    = 0;
        m_rests = 0;
        m_skips = 0;
        m_total = 0;
        m_done  = 0;
    endtask

    // Code n plays n beeps; the session-done code plays double-length beeps.
    task automatic push_pattern(input int code);
        int len;
        len = (code == 3) ? 2 * ON_T : ON_T;
        for (int b = 0; b < code; b++) begin
            for (int i = 0; i < len; i++) sched.push_back(1);
            for (int i = 0; i < OFF_T; i++) sched.push_back(0);
        end
    endtask

    task automatic model_edge(input int code, input int cn, output int eb, output int ebusy);
        if (code == 3) begin
            sched.delete();
            pend = 0;
            push_pattern(3);
        end else if (sched.size() == 0) begin
            if (pend != 0) begin
                push_pattern(pend);
                pend = code;
            end else if (code != 0) begin
                push_pattern(code);
            end
        end else if (code != 0 && code > pend) begin
            pend = code;
        end
        if (sched.size() > 0) begin
            eb    = sched.pop_front();
            ebusy = 1;
        end else begin
            eb    = 0;
            ebusy = 0;
        end
        if (code == 1 && m_rests < 511) m_rests++;
        if (code == 2 && m_skips < 511) m_skips++;
        if (code == 3) begin
            m_total = cn;
            m_done  = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, nstep, obs, exp);
        end
    endtask

    task automatic chk_all(input int eb, input int ebusy);
        chk("buz",   9'(Buz),  9'(eb));
        chk("busy",  9'(Busy), 9'(ebusy));
        chk("rests", Rests,    9'(m_rests));
        chk("skips", Skips,    9'(m_skips));
        chk("total", Total,    9'(m_total));
        chk("done",  9'(Done), 9'(m_done));
    endtask

    task automatic step(input logic [1:0] code, input logic [8:0] cn);
        int eb, ebusy;
        @(negedge Clk);
        if (drop_reset) begin
            Re = 1'b0;
            drop_reset = 0;
        end
        Bu = code;
        Cn = cn;
        @(posedge Clk);
        model_edge(int'(code), int'(cn), eb, ebusy);
        #1;
        nstep++;
        chk_all(eb, ebusy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 9'd0);
    endtask

    initial begin
        int r;
        Re = 1'b1;
        Bu = 2'b00;
        Cn = 9'd0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk_all(0, 0);
        drop_reset = 1;

        // Single rest beep, then a skip pattern, then a session-done pattern.
        step(2'b01, 9'd3);
        idle(8);
        step(2'b10, 9'd4);
        idle(14);
        step(2'b11, 9'd7);
        idle(32);

        // Queueing: 10 overrides a stored 01 and plays after the first pattern.
        step(2'b01, 9'd1);
        step(2'b00, 9'd0);
        step(2'b01, 9'd1);
        step(2'b10, 9'd1);
        idle(20);

        // Preemption of a playing skip pattern by session done.
        step(2'b10, 9'd2);
        idle(4);
        step(2'b11, 9'd9);
        idle(32);

        // Event landing exactly on the completion edge of a pattern.
        step(2'b01, 9'd0);
        idle(5);
        step(2'b10, 9'd0);
        idle(14);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      step(2'b00, 9'($urandom_range(0, 511)));
            else if (r < 85) step(2'b01, 9'($urandom_range(0, 511)));
            else if (r < 97) step(2'b10, 9'($urandom_range(0, 511)));
            else             step(2'b11, 9'($urandom_range(0, 511)));
        end
        idle(32);

        // Asynchronous reset in the middle of a beep.
        step(2'b10, 9'd5);
        idle(2);
        Re = 1'b1;
        #1;
        model_reset();
        chk_all(0, 0);
        drop_reset = 1;
        step(2'b10, 9'd0);
        idle(11);

        for (int k = 0; k < 520; k++) begin
            step(2'b10, 9'd0);
            idle(11);
        end
        chk("skips_sat", Skips, 9'd511);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/buzz_driver.md
Name: buzz_driver

Overview:
- Consumer end of the workout controller's status outputs.
- Samples the one-cycle event code Bu and the set counter Cn each clock.
- Turns each event into an audible beep pattern on a single buzzer line, queuing or preempting overlapping events.
- Keeps session statistics for the display block: rests completed, sets skipped, total sets at session end.

Parameters:
- BEEP_ON, 8, cycles Buz is high for a short beep; a long beep is 2*BEEP_ON.
- BEEP_OFF, 4, cycles Buz is low after every beep, including the last beep of a pattern.

Ports:
- Clk  input  1  system clock, rising edge.
- Re  input  1  reset, asynchronous, active-high.
- Bu  input  2  event code, valid for one cycle: 00 none, 01 rest ended, 10 set skipped, 11 session done.
- Cn  input  9  current set number from the controller.
- Buz  output  1  buzzer drive, registered.
- Busy  output  1  high while a pattern is playing (state != IDLE).
- Rests  output  9  count of 01 events, saturates at 511.
- Skips  output  9  count of 10 events, saturates at 511.
- Total  output  9  Cn captured on the 11 event.
- Done  output  1  sticky, set by the 11 event.

Behaviour:
- Reset (async, Re=1): Buz=0, Busy=0, Rests=0, Skips=0, Total=0, Done=0, state=IDLE, pending empty, all timers 0. Re mid-pattern aborts the pattern immediately.
- Patterns:
  - 01: 1 short beep.
  - 10: 2 short beeps.
  - 11: 3 long beeps.
  - Each beep is Buz high for the ON length, then low for BEEP_OFF cycles.
- Latency: Buz goes high from the first rising edge that samples Bu!=00 (IDLE case). Buz stays high exactly ON-length cycles.
- States:
  - IDLE: Buz=0.
  - ON: Buz=1; beep timer counts down.
  - OFF: Buz=0; gap timer counts down.
- Transitions:
  - ON -> OFF when the ON timer expires.
  - OFF -> ON while beeps remain.
  - OFF -> (pending start | IDLE) after the last gap.
- Internal registers:
  - beeps-remaining (2 bits).
  - long flag.
  - timer, width $clog2(2*BEEP_ON+1).
  - pending code (2 bits, 00 = empty).
- Event handling:
  - 11 arriving in any state preempts. At that edge: pending cleared, state=ON, timer reloaded, 3 long beeps.
  - 01 or 10 arriving in IDLE starts its pattern at that edge.
  - 01 or 10 arriving while Busy:
    - If pending is empty, it is stored.
    - If pending is full, pending keeps the larger code value (10 beats 01).
  - Completion edge (last OFF cycle expires):
    - If pending is valid, start pending. An incoming 01/10 on the same edge then becomes the new pending.
    - Else if incoming is valid, start incoming.
    - Else go to IDLE.
- Statistics update on the sampling edge, independent of buzzer queuing; dropped patterns are still counted.
  - Rests+1 on 01; Skips+1 on 10; both saturate at 511.
  - On 11: Total<=Cn and Done<=1.
  - Done clears only on Re.
- Bu arriving in the same cycle Re deasserts is sampled normally at the next edge.

Decomposition:
- Shared package fr_pkg:
  - Bu code constants BU_NONE=2'b00, BU_REST=2'b01, BU_SKIP=2'b10, BU_DONE=2'b11.
  - buzz_driver state encoding IDLE/ON/OFF.
  - The controller also imports the Bu constants.
- One sub-module sat_cnt9: 9-bit counter with increment enable, saturating at 511, async active-high reset. Instanced for Rests and Skips.

Test Plan:
All scenarios use BEEP_ON=4, BEEP_OFF=2.
- Bu=01 for one cycle in IDLE -> Buz 1111 then 00; Busy high 6 cycles then low; Rests=1.
- Bu=10 in IDLE -> Buz 1111 00 1111 00 (12 cycles); Skips=1; Rests unchanged.
- Bu=11 with Cn=7 -> three 8-cycle beeps with 2-cycle gaps (30 cycles Busy); Total=7; Done=1.
- Queue: 01 at cycle 0, 01 at cycle 2, 10 at cycle 3.
  - Pending ends as 10.
  - 10 pattern starts at cycle 6 (Buz high cycles 6-9 and 12-15).
  - Rests=2, Skips=1.
- Preempt: 10 pattern playing, 11 at cycle 5 -> Buz=1 from the edge sampling 11 for 8 cycles; pending cleared; 10 pattern does not resume.
- Reset/saturation: assert Re during ON -> Buz=0 at once, all counters 0. Then 520 separate 10 events -> Skips=511.
